tone_decoder: RTL and testbench
===============================

# tone_decoder

Upstream neighbour of the drive state machine in `MainModule`, producing its `tdEn`/`tdDir` inputs. It takes the five band-pass comparator outputs `bp1`..`bp5`, which are asynchronous square waves. For each channel it counts edges over a fixed gate window and decides whether that tone is present. It then debounces the decoded junction command across several windows. `bp5` is the pilot tone, and a command is valid only while the pilot is present.

## Interface
- `GATE_CYCLES`, 500_000: gate window length in `clk` cycles (10 ms at 50 MHz).
- `MIN_EDGES`, 5: minimum rising edges per window for a channel to count as active (inclusive).
- `MAX_EDGES`, 200: maximum rising edges per window for a channel to count as active (inclusive).
- `CONFIRM_WINDOWS`, 3: consecutive identical valid windows required before the command is asserted (≥1).
- `RELEASE_WINDOWS`, 2: consecutive non-matching-invalid windows required before `tdEn` drops (≥1).
- `clk` in 1: 50 MHz system clock.
- `rstN` in 1: asynchronous, active-low reset.
- `bp1`..`bp5` in 1 each: comparator outputs, asynchronous to `clk`.
- `tdEn` out 1: confirmed command present (level).
- `tdDir` out 2: command code. 00 STRAIGHT (`bp1`), 01 LEFT (`bp2`), 10 RIGHT (`bp3`), 11 BACK (`bp4`).
- `toneActive` out 5: per-channel activity from the last completed window. Bit i-1 corresponds to `bp`i.
- `windowDone` out 1: one-cycle pulse marking each window end.

## Operation
- Reset values:
  - Outputs: `tdEn`=0, `tdDir`=00, `toneActive`=0, `windowDone`=0.
  - Internal: all counters 0, state IDLE.
- Input path:
  - Each `bp` input passes through a 2-flop synchronizer.
  - A rising edge is detected as synced=1 while the previous synced value=0.
- Edge counters:
  - One 12-bit counter per channel.
  - Each saturates at 4095, never wrapping.
- Gate counter:
  - 20 bits, counts 0..`GATE_CYCLES`-1, then wraps to 0.
  - The window end is the cycle where the gate counter equals `GATE_CYCLES`-1.
- Window end actions:
  - Each channel's active bit is set when its count is within [`MIN_EDGES`, `MAX_EDGES`]; these bits load `toneActive`.
  - All edge counters clear.
  - An edge detected in the window-end cycle belongs to the new window: its counter loads 1, not 0.
- Decode:
  - valid = active5 AND exactly one of active1..4 set.
  - cmd is the code of that single channel.
  - Zero or several of channels 1..4 active, or the pilot absent, makes the window invalid.
- FSM, evaluated only at window ends. Internal registers: cand(2), matchCnt, missCnt.
  - IDLE: valid → cand=cmd, matchCnt=1. Then go to LOCKED if `CONFIRM_WINDOWS`==1, otherwise CONFIRM. Invalid → stay.
  - CONFIRM, valid with cmd==cand: matchCnt+1. On reaching `CONFIRM_WINDOWS` go to LOCKED.
  - CONFIRM, valid with cmd≠cand: cand=cmd, matchCnt=1, stay.
  - CONFIRM, invalid: go to IDLE, matchCnt=0.
  - LOCKED entry: `tdEn`=1, `tdDir`=cand, missCnt=0.
  - LOCKED, valid with cmd==cand: missCnt=0.
  - LOCKED, valid with cmd≠cand: `tdEn`=0, cand=cmd, matchCnt=1, go to CONFIRM. A different tone always needs fresh confirmation.
  - LOCKED, invalid: missCnt+1. On reaching `RELEASE_WINDOWS`: `tdEn`=0, go to IDLE.
- `tdDir` holds its last confirmed value while `tdEn`=0. It changes only on LOCKED entry.
- Reset mid-operation: all state clears immediately. The first window starts on the first clock edge after `rstN` deasserts.

## Timing
- Input to edge detect: 3 `clk` cycles (2 sync + 1 edge register).
- `windowDone`, `toneActive`, `tdEn` and `tdDir` all update on the clock edge following the window-end cycle.
- `windowDone` is high for exactly that one cycle.
- `tdEn` rise:
  - Occurs one cycle after the `CONFIRM_WINDOWS`-th consecutive matching window end.
  - Minimum latency from tone onset is `CONFIRM_WINDOWS`×`GATE_CYCLES`, plus 0..`GATE_CYCLES` alignment, plus 4 cycles.
- `tdEn` fall, tone removed:
  - Occurs one cycle after the `RELEASE_WINDOWS`-th invalid window end.
  - A partial window containing the removal may still read as active.
- `tdEn` fall, different valid tone: one cycle after the first window end that decodes the new tone.
- No combinational path from any `bp` input to any output.

## Test plan
Sim parameters: `GATE_CYCLES`=1000, `MIN_EDGES`=5, `MAX_EDGES`=50, `CONFIRM_WINDOWS`=3, `RELEASE_WINDOWS`=2.

- Reset: hold `rstN`=0 with all `bp` toggling → all outputs 0. Release → first `windowDone` at cycle 1000 after release.
- Pilot plus LEFT: `bp5` and `bp2` with 40-cycle period (25 edges/window) → `toneActive`=5'b10010 after window 1. `tdEn`=1, `tdDir`=01 one cycle after the 3rd window end.
- Ambiguous or no pilot:
  - `bp5`+`bp1`+`bp3` active → `tdEn` stays 0.
  - `bp3` alone (no `bp5`) → `tdEn` stays 0, `toneActive`=5'b00100.
- Out of band: `bp5`+`bp4` with 10-cycle period (100 edges) → `toneActive`=0, no `tdEn`. With 400-cycle period (2–3 edges) → bits 4 and 3 stay 0, no `tdEn`.
- Release and switch:
  - Locked RIGHT (`tdDir`=10), then stop `bp3` → `tdEn` still 1 after 1 invalid window, 0 after 2nd; `tdDir` stays 10.
  - Locked RIGHT, then switch to `bp1` → `tdEn` drops at the first `bp1` window. It re-asserts with `tdDir`=00 after 2 more windows.
- Reset mid-CONFIRM: assert `rstN` after window 2 of a valid tone → outputs 0 immediately. After release, a full 3 windows are needed for `tdEn`.

Source files
------------

// File: rtl/tone_decoder.sv
// tone_decoder: counts rising edges of five asynchronous band-pass comparator
// outputs over a fixed gate window, classifies each channel as active when its
// edge count falls in a band, and debounces the decoded junction command
// (one of bp1..bp4, qualified by the bp5 pilot) across several windows.
module tone_decoder #(
  parameter int GATE_CYCLES     = 500_000,
  parameter int MIN_EDGES       = 5,
  parameter int MAX_EDGES       = 200,
  parameter int CONFIRM_WINDOWS = 3,
  parameter int RELEASE_WINDOWS = 2
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic [4:0] toneActive,
  output logic       windowDone
);

  localparam int          CW          = $clog2(CONFIRM_WINDOWS + 1);
  localparam int          RW          = $clog2(RELEASE_WINDOWS + 1);
  localparam logic [19:0] GATE_LAST   = 20'(GATE_CYCLES - 1);
  localparam logic [11:0] MIN_CNT     = 12'(MIN_EDGES);
  localparam logic [11:0] MAX_CNT     = 12'(MAX_EDGES);
  localparam logic [11:0] SAT_CNT     = 12'hFFF;
  localparam logic [CW-1:0] CONFIRM_CNT = CW'(CONFIRM_WINDOWS);
  localparam logic [RW-1:0] RELEASE_CNT = RW'(RELEASE_WINDOWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  logic [4:0]    sync1_r;
  logic [4:0]    sync2_r;
  logic [4:0]    prev_r;
  logic [4:0]    edge_s;
  logic [11:0]   edge_cnt_r [5];
  logic [19:0]   gate_r;
  logic          window_end_s;
  logic [4:0]    active_s;
  logic          valid_s;
  logic [1:0]    cmd_s;

  state_t        state_r, state_nx;
  logic [1:0]    cand_r, cand_nx;
  logic [CW-1:0] match_r, match_nx;
  logic [CW-1:0] match_inc_s;
  logic [RW-1:0] miss_r, miss_nx;
  logic [RW-1:0] miss_inc_s;
  logic          td_en_r, td_en_nx;
  logic [1:0]    td_dir_r, td_dir_nx;
  logic [4:0]    tone_active_r;
  logic          window_done_r;

  // Two-flop synchronizer plus the previous-value flop used for edge detection.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_r <= 5'd0;
      sync2_r <= 5'd0;
      prev_r  <= 5'd0;
    end else begin
      sync1_r <= {bp5, bp4, bp3, bp2, bp1};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign edge_s       = sync2_r & ~prev_r;
  assign window_end_s = (gate_r == GATE_LAST);

  // Gate counter: free-running 0..GATE_CYCLES-1, restarting on reset release.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      gate_r <= 20'd0;
    end else if (window_end_s) begin
      gate_r <= 20'd0;
    end else begin
      gate_r <= gate_r + 20'd1;
    end
  end

  // Saturating per-channel edge counters; an edge on the window-end cycle seeds the next window.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 5; i++) begin
        edge_cnt_r[i] <= 12'd0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (window_end_s) begin
          edge_cnt_r[i] <= edge_s[i] ? 12'd1 : 12'd0;
        end else if (edge_s[i] && (edge_cnt_r[i] != SAT_CNT)) begin
          edge_cnt_r[i] <= edge_cnt_r[i] + 12'd1;
        end else begin
          edge_cnt_r[i] <= edge_cnt_r[i];
        end
      end
    end
  end

  // In-band classification of the running counts (meaningful at window end).
  always_comb begin
    active_s = 5'd0;
    for (int i = 0; i < 5; i++) begin
      active_s[i] = (edge_cnt_r[i] >= MIN_CNT) && (edge_cnt_r[i] <= MAX_CNT);
    end
  end

  // Command decode: pilot present and exactly one command channel active.
  always_comb begin
    cmd_s   = 2'b00;
    valid_s = 1'b0;
    case (active_s[3:0])
      4'b0001: begin cmd_s = 2'b00; valid_s = active_s[4]; end
      4'b0010: begin cmd_s = 2'b01; valid_s = active_s[4]; end
      4'b0100: begin cmd_s = 2'b10; valid_s = active_s[4]; end
      4'b1000: begin cmd_s = 2'b11; valid_s = active_s[4]; end
      default: begin cmd_s = 2'b00; valid_s = 1'b0; end
    endcase
  end

  assign match_inc_s = match_r + CW'(1);
  assign miss_inc_s  = miss_r + RW'(1);

  // Debounce FSM next-state and output logic, evaluated only on window ends.
  always_comb begin
    state_nx  = state_r;
    cand_nx   = cand_r;
    match_nx  = match_r;
    miss_nx   = miss_r;
    td_en_nx  = td_en_r;
    td_dir_nx = td_dir_r;
    if (window_end_s) begin
      case (state_r)
        IDLE: begin
          if (valid_s) begin
            cand_nx  = cmd_s;
            match_nx = CW'(1);
            if (CONFIRM_WINDOWS == 1) begin
              state_nx  = LOCKED;
              td_en_nx  = 1'b1;
              td_dir_nx = cmd_s;
              miss_nx   = RW'(0);
            end else begin
              state_nx = CONFIRM;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        CONFIRM: begin
          if (valid_s) begin
            if (cmd_s == cand_r) begin
              match_nx = match_inc_s;
              if (match_inc_s >= CONFIRM_CNT) begin
                state_nx  = LOCKED;
                td_en_nx  = 1'b1;
                td_dir_nx = cand_r;
                miss_nx   = RW'(0);
              end else begin
                state_nx = CONFIRM;
              end
            end else begin
              cand_nx  = cmd_s;
              match_nx = CW'(1);
            end
          end else begin
            state_nx = IDLE;
            match_nx = CW'(0);
          end
        end
        LOCKED: begin
          if (valid_s) begin
            if (cmd_s == cand_r) begin
              miss_nx = RW'(0);
            end else begin
              // A different tone never inherits the lock; it must re-confirm.
              td_en_nx = 1'b0;
              cand_nx  = cmd_s;
              match_nx = CW'(1);
              state_nx = CONFIRM;
            end
          end else begin
            if (miss_inc_s >= RELEASE_CNT) begin
              td_en_nx = 1'b0;
              miss_nx  = RW'(0);
              state_nx = IDLE;
            end else begin
              miss_nx = miss_inc_s;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          td_en_nx = 1'b0;
        end
      endcase
    end else begin
      state_nx = state_r;
    end
  end

  // FSM state, debounce counters and command outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r  <= IDLE;
      cand_r   <= 2'b00;
      match_r  <= CW'(0);
      miss_r   <= RW'(0);
      td_en_r  <= 1'b0;
      td_dir_r <= 2'b00;
    end else begin
      state_r  <= state_nx;
      cand_r   <= cand_nx;
      match_r  <= match_nx;
      miss_r   <= miss_nx;
      td_en_r  <= td_en_nx;
      td_dir_r <= td_dir_nx;
    end
  end

  // Per-window activity snapshot and the window-end pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tone_active_r <= 5'd0;
      window_done_r <= 1'b0;
    end else begin
      window_done_r <= window_end_s;
      if (window_end_s) begin
        tone_active_r <= active_s;
      end else begin
        tone_active_r <= tone_active_r;
      end
    end
  end

  assign tdEn       = td_en_r;
  assign tdDir      = td_dir_r;
  assign toneActive = tone_active_r;
  assign windowDone = window_done_r;

endmodule

// File: tb/tb_tone_decoder.sv
// Testbench for tone_decoder: table-driven window sequence, reset corner
// cases, then randomized windows checked against a behavioural model.
module tb_tone_decoder;

  localparam int GATE = 1000;
  localparam int MINE = 5;
  localparam int MAXE = 50;
  localparam int CONF = 3;
  localparam int REL  = 2;

  logic       clk;
  logic       rstN;
  logic [4:0] bp;
  logic       tdEn;
  logic [1:0] tdDir;
  logic [4:0] toneActive;
  logic       windowDone;

  int tests;
  int fails;
  int cyc;
  bit rst_noise;
  int pat_n [5];
  int pat_p [5];

  // behavioural model state
  bit       m_locked;
  bit [1:0] m_dir;
  bit [1:0] m_cand;
  int       m_streak;
  int       m_miss;

  typedef struct {
    logic [4:0] mask;
    int         n;
    int         p;
    logic [4:0] act;
    logic       en;
    logic [1:0] dir;
  } vec_t;

  vec_t tbl [24];

  tone_decoder #(
    .GATE_CYCLES(GATE), .MIN_EDGES(MINE), .MAX_EDGES(MAXE),
    .CONFIRM_WINDOWS(CONF), .RELEASE_WINDOWS(REL)
  ) dut (
    .clk(clk), .rstN(rstN),
    .bp1(bp[0]), .bp2(bp[1]), .bp3(bp[2]), .bp4(bp[3]), .bp5(bp[4]),
    .tdEn(tdEn), .tdDir(tdDir), .toneActive(toneActive), .windowDone(windowDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycles since reset release; window k ends when cyc reaches k*GATE
  always @(posedge clk or negedge rstN) begin
    if (!rstN) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // square-wave generator: n rising edges of period p starting at offset 20
  initial begin
    bp = 5'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_noise) begin
        bp = 5'($urandom);
      end else begin
        for (int c = 0; c < 5; c++) begin
          int t;
          t = cyc % GATE;
          if (pat_n[c] > 0 && t >= 20 && t < 20 + pat_n[c] * pat_p[c])
            bp[c] = (((t - 20) % pat_p[c]) < (pat_p[c] / 2));
          else
            bp[c] = 1'b0;
        end
      end
    end
  end

  // windowDone must pulse exactly at each window end and nowhere else
  always @(negedge clk) begin
    logic exp_wd;
    exp_wd = rstN && (cyc != 0) && ((cyc % GATE) == 0);
    tests++;
    if (windowDone !== exp_wd) begin
      fails++;
      $display("FAIL windowDone cyc=%0d got=%b want=%b", cyc, windowDone, exp_wd);
    end
  end

  function automatic vec_t mk(logic [4:0] mask, int n, int p, logic [4:0] act,
                              logic en, logic [1:0] dir);
    vec_t v;
    v.mask = mask; v.n = n; v.p = p; v.act = act; v.en = en; v.dir = dir;
    return v;
  endfunction

  task automatic check(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d (cyc=%0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_dir = 2'b00; m_cand = 2'b00; m_streak = 0; m_miss = 0;
  endtask

  // debouncing rules: CONF consecutive identical valid windows lock a
  // command, REL invalid windows release it, a different valid tone unlocks
  // immediately and starts a fresh run
  task automatic model_window(input logic [4:0] act);
    bit       valid;
    bit [1:0] cmd;
    valid = act[4] && ($countones(act[3:0]) == 1);
    cmd = 2'b00;
    for (int i = 0; i < 4; i++) if (act[i]) cmd = 2'(i);
    if (valid) begin
      if (m_locked) begin
        if (cmd == m_dir) m_miss = 0;
        else begin m_locked = 1'b0; m_cand = cmd; m_streak = 1; end
      end else begin
        if (m_streak > 0 && cmd == m_cand) m_streak++;
        else begin m_cand = cmd; m_streak = 1; end
        if (m_streak >= CONF) begin
          m_locked = 1'b1; m_dir = cmd; m_miss = 0; m_streak = 0;
        end
      end
    end else begin
      m_streak = 0;
      if (m_locked) begin
        m_miss++;
        if (m_miss >= REL) begin m_locked = 1'b0; m_miss = 0; end
      end
    end
  endtask

  // apply a per-channel pattern for one window and check its outcome
  task automatic run_window(output logic [4:0] exp_act);
    int k;
    exp_act = 5'd0;
    for (int c = 0; c < 5; c++)
      exp_act[c] = (pat_n[c] >= MINE) && (pat_n[c] <= MAXE);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (windowDone !== 1'b1 && k < GATE + 100);
    if (windowDone !== 1'b1) begin
      tests++; fails++;
      $display("FAIL window_timeout waited=%0d cycles", k);
    end else begin
      model_window(exp_act);
      check("toneActive_model", toneActive, exp_act);
      check("tdEn_model", tdEn, m_locked);
      check("tdDir_model", tdDir, m_dir);
    end
  endtask

  task automatic set_pat(logic [4:0] mask, int n, int p);
    for (int c = 0; c < 5; c++) begin
      pat_n[c] = mask[c] ? n : 0;
      pat_p[c] = p;
    end
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_tdEn"}, tdEn, 0);
    check({tag, "_tdDir"}, tdDir, 0);
    check({tag, "_toneActive"}, toneActive, 0);
    check({tag, "_windowDone"}, windowDone, 0);
  endtask

  initial begin
    logic [4:0] act;
    int prim;
    tests = 0; fails = 0; rst_noise = 1'b1; rstN = 1'b0;
    set_pat(5'd0, 0, 4);
    model_reset();

    tbl[0]  = mk(5'b10010, 25, 40,  5'b10010, 1'b0, 2'b00);
    tbl[1]  = mk(5'b10010, 25, 40,  5'b10010, 1'b0, 2'b00);
    tbl[2]  = mk(5'b10010, 25, 40,  5'b10010, 1'b1, 2'b01);
    tbl[3]  = mk(5'b10101, 25, 20,  5'b10101, 1'b1, 2'b01);
    tbl[4]  = mk(5'b10101, 25, 20,  5'b10101, 1'b0, 2'b01);
    tbl[5]  = mk(5'b00100, 25, 30,  5'b00100, 1'b0, 2'b01);
    tbl[6]  = mk(5'b11000, 100, 8,  5'b00000, 1'b0, 2'b01);
    tbl[7]  = mk(5'b11000, 2, 400,  5'b00000, 1'b0, 2'b01);
    tbl[8]  = mk(5'b11000, 3, 300,  5'b00000, 1'b0, 2'b01);
    tbl[9]  = mk(5'b11000, 4, 100,  5'b00000, 1'b0, 2'b01);
    tbl[10] = mk(5'b11000, 5, 100,  5'b11000, 1'b0, 2'b01);
    tbl[11] = mk(5'b11000, 50, 10,  5'b11000, 1'b0, 2'b01);
    tbl[12] = mk(5'b11000, 51, 10,  5'b00000, 1'b0, 2'b01);
    tbl[13] = mk(5'b10100, 25, 40,  5'b10100, 1'b0, 2'b01);
    tbl[14] = mk(5'b10100, 25, 40,  5'b10100, 1'b0, 2'b01);
    tbl[15] = mk(5'b10100, 25, 40,  5'b10100, 1'b1, 2'b10);
    tbl[16] = mk(5'b10000, 25, 40,  5'b10000, 1'b1, 2'b10);
    tbl[17] = mk(5'b10000, 25, 40,  5'b10000, 1'b0, 2'b10);
    tbl[18] = mk(5'b10100, 25, 40,  5'b10100, 1'b0, 2'b10);
    tbl[19] = mk(5'b10100, 25, 40,  5'b10100, 1'b0, 2'b10);
    tbl[20] = mk(5'b10100, 25, 40,  5'b10100, 1'b1, 2'b10);
    tbl[21] = mk(5'b10001, 25, 40,  5'b10001, 1'b0, 2'b10);
    tbl[22] = mk(5'b10001, 25, 40,  5'b10001, 1'b0, 2'b10);
    tbl[23] = mk(5'b10001, 25, 40,  5'b10001, 1'b1, 2'b00);

    // reset held with inputs toggling
    repeat (20) @(negedge clk);
    check_zero_outputs("in_reset_a");
    repeat (7) @(negedge clk);
    check_zero_outputs("in_reset_b");
    rst_noise = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    // table-driven window sequence
    for (int i = 0; i < 24; i++) begin
      set_pat(tbl[i].mask, tbl[i].n, tbl[i].p);
      run_window(act);
      if (i == 0) check("first_window_cycle", cyc, GATE);
      check($sformatf("tbl%0d_toneActive", i), toneActive, tbl[i].act);
      check($sformatf("tbl%0d_tdEn", i), tdEn, tbl[i].en);
      check($sformatf("tbl%0d_tdDir", i), tdDir, tbl[i].dir);
    end

    // reset in the middle of confirming BACK
    set_pat(5'b11000, 25, 40);
    run_window(act);
    run_window(act);
    check("pre_reset_toneActive", toneActive, 5'b11000);
    check("pre_reset_tdEn", tdEn, 0);
    repeat (300) @(negedge clk);
    rstN = 1'b0;
    #1;
    model_reset();
    check_zero_outputs("mid_reset");
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    run_window(act);
    check("after_reset_w1_tdEn", tdEn, 0);
    run_window(act);
    check("after_reset_w2_tdEn", tdEn, 0);
    run_window(act);
    check("after_reset_w3_tdEn", tdEn, 1);
    check("after_reset_w3_tdDir", tdDir, 2'b11);

    // randomized windows against the model
    prim = 0;
    for (int w = 0; w < 30; w++) begin
      if ($urandom_range(99) < 30) prim = $urandom_range(3);
      for (int c = 0; c < 5; c++) begin
        bit on;
        int n;
        int pmax;
        on = (c == prim) || (c == 4 && $urandom_range(99) < 85) ||
             (c < 4 && c != prim && $urandom_range(99) < 8);
        if (on) begin
          if ($urandom_range(99) < 15) begin
            case ($urandom_range(5))
              0: n = 3;
              1: n = 4;
              2: n = 5;
              3: n = 50;
              4: n = 51;
              default: n = 60;
            endcase
          end else begin
            n = $urandom_range(MAXE, MINE);
          end
        end else begin
          n = ($urandom_range(99) < 10) ? $urandom_range(4, 1) : 0;
        end
        pmax = (n > 0) ? (940 / n) : 40;
        if (pmax > 40) pmax = 40;
        pat_n[c] = n;
        pat_p[c] = $urandom_range(pmax, 4);
      end
      run_window(act);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
